// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - write strobe, transmitter handshake and queue status bundle
interface uart_tx_queue_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              tx_active;
    logic              tx_done;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_timeout;

    modport master (
        output wr_en, wr_data, tx_active, tx_done,
        input  tx_dv, tx_byte, full, empty, count, overflow, tx_timeout
    );

    modport slave (
        input  wr_en, wr_data, tx_active, tx_done,
        output tx_dv, tx_byte, full, empty, count, overflow, tx_timeout
    );
endinterface

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - circular byte FIFO feeding a UART transmitter via DV/Active/Done with timeout recovery
module uart_tx_queue #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 10000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_queue_if.slave bus
);
    localparam int CW = ADDR_W + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            state, state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0]     timer;
    logic              push, pop, expire;
    logic [CW-1:0]     count_next;

    // full is the registered flag, so a write while full is dropped even if a pop happens this cycle
    assign push = bus.wr_en && !bus.full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.empty && !bus.tx_active) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: state_next = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    state_next = IDLE;
                end else if (TIMEOUT != 0 && timer == TW'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = bus.count;
        if (push && !pop)      count_next = bus.count + CW'(1);
        else if (!push && pop) count_next = bus.count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            timer          <= '0;
            bus.tx_dv      <= 1'b0;
            bus.tx_byte    <= 8'h00;
            bus.full       <= 1'b0;
            bus.empty      <= 1'b1;
            bus.count      <= '0;
            bus.overflow   <= 1'b0;
            bus.tx_timeout <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                bus.tx_byte <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + ADDR_W'(1);
            end
            if (state == SEND)
                timer <= '0;
            else if (state == WAIT && !bus.tx_done && !expire)
                timer <= timer + TW'(1);
            bus.tx_dv      <= pop;
            bus.tx_timeout <= expire;
            bus.overflow   <= bus.wr_en && bus.full;
            bus.count      <= count_next;
            bus.full       <= (count_next == CW'(DEPTH));
            bus.empty      <= (count_next == '0);
        end
    end
endmodule
